// File: rtl/sync_fifo_ptr_if.sv
// Handshake and status bundle between a FIFO and its producer/consumer.
// The master side drives requests and write data; the slave side is the FIFO.
interface sync_fifo_ptr_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ptr.sv
// Single-clock FIFO using (ADDR_W+1)-bit wrap-bit pointers to separate full from empty,
// with a registered read port and sticky overflow/underflow flags.
module sync_fifo_ptr #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned AFULL_TH = 56
) (
    input logic                  clk,
    input logic                  rst,
    sync_fifo_ptr_if.slave       bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AfullTh = (ADDR_W + 1)'(AFULL_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              full, empty;
    logic              wr_accept, rd_accept;
    logic [ADDR_W:0]   count;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // Acceptance uses pre-edge flags: no write-through when empty, no read-through when full.
    assign wr_accept = bus.wr_en && !full;
    assign rd_accept = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_accept;
        overflow_d  = overflow_q  || (bus.wr_en && full);
        underflow_d = underflow_q || (bus.rd_en && empty);
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count >= AfullTh);
    assign bus.count       = count;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ptr.sv
// Directed bench for sync_fifo_ptr: a queue-based reference predicts every flag and read word,
// and each sampled output is compared with an immediate assertion.
module tb_sync_fifo_ptr;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned AFULL_TH = 56;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sync_fifo_ptr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sync_fifo_ptr #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .AFULL_TH(AFULL_TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] fifo_m [$];
    logic [DATA_W-1:0] exp_q  [$];
    logic [DATA_W-1:0] rd_m;
    logic              ovf_m, udf_m, rdv_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [DATA_W-1:0] e;
        check("rd_valid", 32'(bus.rd_valid), 32'(rdv_m));
        if (bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_spurious", 32'(bus.rd_valid), 32'(0));
            end else begin
                e    = exp_q.pop_front();
                rd_m = e;
                check("rd_data", 32'(bus.rd_data), 32'(e));
            end
        end else begin
            check("rd_hold", 32'(bus.rd_data), 32'(rd_m));
        end
        check("count", 32'(bus.count), 32'(fifo_m.size()));
        check("empty", 32'(bus.empty), 32'(fifo_m.size() == 0));
        check("full", 32'(bus.full), 32'(fifo_m.size() == DEPTH));
        check("almost_full", 32'(bus.almost_full), 32'(fifo_m.size() >= AFULL_TH));
        check("overflow", 32'(bus.overflow), 32'(ovf_m));
        check("underflow", 32'(bus.underflow), 32'(udf_m));
    endtask

    // One clock with the given requests; the reference decides acceptance from pre-edge occupancy.
    task automatic cycle(input logic wr, input logic [DATA_W-1:0] wd, input logic rd);
        bit wa, ra;
        wa = wr && (fifo_m.size() < DEPTH);
        ra = rd && (fifo_m.size() > 0);
        if (wr && fifo_m.size() == DEPTH) ovf_m = 1'b1;
        if (rd && fifo_m.size() == 0) udf_m = 1'b1;
        if (ra) exp_q.push_back(fifo_m.pop_front());
        if (wa) fifo_m.push_back(wd);
        rdv_m       = ra;
        bus.wr_en   = wr;
        bus.wr_data = wd;
        bus.rd_en   = rd;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int n, input logic wr, input logic rd);
        rst         = 1'b1;
        bus.wr_en   = wr;
        bus.wr_data = 8'h77;
        bus.rd_en   = rd;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_m.delete();
        exp_q.delete();
        rd_m  = '0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        rdv_m = 1'b0;
        check_outputs();
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        rd_m  = '0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        rdv_m = 1'b0;

        // Reset and idle
        do_reset(2, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);

        // Fill, overflow, drain
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 64; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Pointer wrap under concurrent traffic
        do_reset(1, 1'b0, 1'b0);
        cycle(1'b1, 8'hF0, 1'b0);
        for (int i = 0; i < 200; i++) cycle(1'b1, 8'(i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Simultaneous access while full
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Simultaneous access while empty
        do_reset(1, 1'b0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Mid-operation reset with both requests asserted
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'hEE, 1'b0);
        cycle(1'b1, 8'hEF, 1'b1);
        cycle(1'b1, 8'hEF, 1'b1);
        do_reset(1, 1'b1, 1'b1);
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b1, 8'h5B, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ptr.md
# sync_fifo_ptr

Synchronous single-clock FIFO built around two (ADDR_W+1)-bit modulo-2^(ADDR_W+1) pointers: the extra wrap bit separates full from empty. It buffers a write-side producer stream for a read-side consumer and exports full/empty/count/almost-full status. It consumes the wrap-bit pointer scheme of the mod-2^n address counter stage and adds storage, handshake gating and error flags.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 6, address width; depth DEPTH = 2^ADDR_W (64 words by default)
- AFULL_TH, 56, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word, sampled when the write is accepted
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  one-cycle pulse: rd_data holds a newly read word
- full  out  1  DEPTH words stored
- empty  out  1  no words stored
- almost_full  out  1  count >= AFULL_TH
- count  out  ADDR_W+1  words stored, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DATA_W register array indexed by pointer bits [ADDR_W-1:0]. The array is not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits wide. Each increments by 1 modulo 2^(ADDR_W+1) on an accepted access. Wrap from all-ones to 0 is silent.
- empty = (wr_ptr == rd_ptr).
- full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]).
- count = (wr_ptr - rd_ptr) mod 2^(ADDR_W+1). It is never wider than ADDR_W+1 bits, and full implies count == DEPTH.
- Write accept: wr_en && !full. The write stores wr_data at mem[wr_ptr low bits] and increments wr_ptr.
- Read accept: rd_en && !empty. The read loads rd_data <= mem[rd_ptr low bits], sets rd_valid = 1 for the next cycle, and increments rd_ptr. Otherwise rd_valid = 0 and rd_data holds its last value.
- Acceptance is decided from the flags as they stand before the clock edge:
  - Simultaneous wr_en && rd_en while full: the read is accepted, the write is rejected, and overflow is set.
  - Simultaneous wr_en && rd_en while empty: the write is accepted, the read is rejected, and underflow is set. There is no fall-through.
  - Simultaneous accepted read and write, neither flag set: count is unchanged and both pointers advance.
- overflow is set on wr_en && full. underflow is set on rd_en && empty. Both stay set until rst.
- Reset: rst dominates wr_en and rd_en in the same cycle, and all stored contents are logically discarded. A reset asserted mid-stream returns the block to the post-reset state on the next edge.
- Post-reset values:
  - wr_ptr = 0, rd_ptr = 0
  - empty = 1, full = 0, almost_full = 0, count = 0
  - rd_valid = 0, rd_data = 0
  - overflow = 0, underflow = 0

## Timing
- full, empty, almost_full and count are combinational from the registered pointers. They reflect an access from the cycle after its accepting edge.
- Read latency is 1 cycle: rd_en is accepted at edge N, and rd_data/rd_valid are valid after edge N.
- Write-to-read visibility: a word written at edge N clears empty after edge N, so it can be accepted as a read at edge N+1 and appears on rd_data after N+1.
- Sustained throughput is one write and one read per cycle with no bubbles.
- overflow and underflow rise on the cycle after the offending edge.

## Test plan
- Reset and idle:
  - Stimulus: rst high for 2 cycles, then idle.
  - Required: empty=1, full=0, count=0, rd_valid=0, overflow=0, underflow=0, rd_data=0.
- Fill, overflow, drain (defaults):
  - Stimulus: write 0x00..0x3F; then one extra write with 0xAA while full; then read 64 times.
  - Required: count=56 raises almost_full; full=1 at count=64; the extra write is dropped and overflow=1; reads return 0x00..0x3F in order with one-cycle rd_valid pulses; empty=1 at the end.
- Pointer wrap:
  - Stimulus: 200 cycles of concurrent write and read with an incrementing pattern.
  - Required: count never exceeds 1 and data stays in order across pointer wrap (wr_ptr passes 127 -> 0).
- Simultaneous at boundaries:
  - Stimulus 1: wr_en && rd_en while full.
  - Required: count 64 -> 63, head word output, overflow=1.
  - Stimulus 2: wr_en && rd_en while empty.
  - Required: count 0 -> 1, rd_valid=0, underflow=1.
- Mid-operation reset:
  - Stimulus: write 10 words; assert rst in the same cycle as wr_en and rd_en.
  - Required: next cycle count=0, empty=1, rd_valid=0, sticky flags cleared; the subsequent first read returns the first post-reset word.
